// File: rtl/iram_rr_arbiter_if.sv
// Core-side fetch bus and RAM-side read bus of the instruction RAM arbiter.
// The slave modport is the arbiter; the master modport is the cores plus the RAM.
interface iram_rr_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);
  logic [NUM_CORES-1:0]        core_en;
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES-1:0]        core_gnt;
  logic [NUM_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]           core_rdata;
  logic [ADDR_W-1:0]           iram_addr;
  logic [DATA_W-1:0]           iram_rdata;

  modport master (
    output core_en, core_req, core_addr, iram_rdata,
    input  core_gnt, core_rvalid, core_rdata, iram_addr
  );

  modport slave (
    input  core_en, core_req, core_addr, iram_rdata,
    output core_gnt, core_rvalid, core_rdata, iram_addr
  );
endinterface

// File: rtl/iram_rr_arbiter.sv
// Round-robin arbiter sharing a one-cycle registered instruction RAM among NUM_CORES fetchers.
// Optional per-core grant/stall counters are enabled by the IRAM_ARB_STATS_EN macro.
module iram_rr_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ID_W      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef IRAM_ARB_STATS_EN
  input  logic [ID_W-1:0]     stat_sel,
  input  logic                stat_clr,
  output logic [31:0]         stat_count,
`endif
  iram_rr_arbiter_if.slave    bus
);

  logic [ID_W-1:0]      r_rr_ptr;
  logic                 r_owner_valid;
  logic [ID_W-1:0]      r_owner_id;
  logic [ADDR_W-1:0]    r_addr_hold;

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found;
  logic                 w_grant;
  logic [ID_W-1:0]      w_winner;
  logic [NUM_CORES-1:0] w_gnt;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [ID_W-1:0]      w_ptr_next;

  assign w_elig = bus.core_req & bus.core_en;

  // Scan from r_rr_ptr upward with wraparound; first eligible core wins.
  always_comb begin
    logic [ID_W:0]   v_sum;
    logic [ID_W-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_sum    = '0;
    v_idx    = '0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      v_sum = (ID_W+1)'(r_rr_ptr) + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_CORES)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_CORES);
      end
      v_idx = v_sum[ID_W-1:0];
      if (!w_found && w_elig[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted and then dropped.
  assign w_grant    = w_found & rst_n;
  assign w_gnt      = w_grant ? (NUM_CORES'(1) << w_winner) : '0;
  assign w_win_addr = bus.core_addr[w_winner*ADDR_W +: ADDR_W];
  assign w_ptr_next = (w_winner == ID_W'(NUM_CORES - 1)) ? '0 : w_winner + 1'b1;

  assign bus.core_gnt    = w_gnt;
  assign bus.iram_addr   = w_grant ? w_win_addr : r_addr_hold;
  assign bus.core_rvalid = r_owner_valid ? (NUM_CORES'(1) << r_owner_id) : '0;
  assign bus.core_rdata  = bus.iram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_owner_valid <= 1'b0;
      r_owner_id    <= '0;
      r_addr_hold   <= '0;
    end else begin
      r_owner_valid <= w_grant;
      if (w_grant) begin
        r_owner_id  <= w_winner;
        r_addr_hold <= w_win_addr;
        r_rr_ptr    <= w_ptr_next;
      end
    end
  end

`ifdef IRAM_ARB_STATS_EN
  logic [31:0] r_gnt_cnt   [NUM_CORES];
  logic [31:0] r_stall_cnt [NUM_CORES];
  logic [31:0] r_stat_count;
  logic [31:0] w_sel_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        r_gnt_cnt[i]   <= '0;
        r_stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (stat_clr) begin
          r_gnt_cnt[i]   <= '0;
          r_stall_cnt[i] <= '0;
        end else begin
          if (w_gnt[i] && (r_gnt_cnt[i] != 32'hFFFF_FFFF)) begin
            r_gnt_cnt[i] <= r_gnt_cnt[i] + 32'd1;
          end
          if (w_elig[i] && !w_gnt[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
            r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
          end
        end
      end
    end
  end

  always_comb begin
    w_sel_cnt = '0;
    if (32'(stat_sel) < NUM_CORES) begin
      w_sel_cnt = r_gnt_cnt[stat_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_count <= '0;
    end else begin
      r_stat_count <= w_sel_cnt;
    end
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_iram_rr_arbiter.sv
// Directed self-checking bench for iram_rr_arbiter; RAM model returns address + 2.
module tb_iram_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  iram_rr_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) bus ();

`ifdef IRAM_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic        stat_clr;
  logic [31:0] stat_count;
  assign stat_sel = 2'd0;
  assign stat_clr = 1'b0;
`endif

  iram_rr_arbiter #(
    .NUM_CORES(4),
    .ADDR_W   (16),
    .DATA_W   (16),
    .ID_W     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef IRAM_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_count(stat_count),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM: RAM[a] = a + 2.
  always @(posedge clk) bus.iram_rdata <= bus.iram_addr + 16'd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] req,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3);
    bus.core_en   = en;
    bus.core_req  = req;
    bus.core_addr = {a3, a2, a1, a0};
  endtask

  // Entered at posedge+1; checks combinational outputs mid-cycle, then advances one cycle.
  task automatic step(input string tag, input logic [3:0] en, input logic [3:0] req,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3,
                      input logic [3:0] egnt, input logic [15:0] eaddr,
                      input logic [3:0] erv, input logic [15:0] erd);
    drive(en, req, a0, a1, a2, a3);
    #4;
    chk({tag, ".gnt"}, 32'(bus.core_gnt), 32'(egnt));
    chk({tag, ".addr"}, 32'(bus.iram_addr), 32'(eaddr));
    chk({tag, ".rvalid"}, 32'(bus.core_rvalid), 32'(erv));
    if (erv != 4'b0000) chk({tag, ".rdata"}, 32'(bus.core_rdata), 32'(erd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic [15:0] e_addr;
    logic [15:0] e_rd;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 16'd10, 16'd20, 16'd30, 16'd40);
    #2;
    chk("reset.gnt", 32'(bus.core_gnt), 32'h0);
    chk("reset.rvalid", 32'(bus.core_rvalid), 32'h0);
    @(posedge clk);
    #1;
    chk("reset.gnt2", 32'(bus.core_gnt), 32'h0);
    chk("reset.addr", 32'(bus.iram_addr), 32'h0);
    rst_n = 1'b1;

    // Single core 2, then pointer wrap from 3 with cores 1 and 3.
    step("single.c0", 4'hF, 4'b0100, 16'h0, 16'h0, 16'h5, 16'h0, 4'b0100, 16'h5, 4'b0000, 16'h0);
    step("single.c1", 4'hF, 4'b0000, 16'h0, 16'h0, 16'h5, 16'h0, 4'b0000, 16'h5, 4'b0100, 16'h7);
    step("wrap.c0", 4'hF, 4'b1010, 16'h0, 16'h11, 16'h0, 16'h33, 4'b1000, 16'h33, 4'b0000, 16'h0);
    step("wrap.c1", 4'hF, 4'b0010, 16'h0, 16'h11, 16'h0, 16'h33, 4'b0010, 16'h11, 4'b1000, 16'h35);
    step("wrap.c2", 4'hF, 4'b0110, 16'h0, 16'h12, 16'h22, 16'h0, 4'b0100, 16'h22, 4'b0010, 16'h13);
    step("wrap.c3", 4'hF, 4'b0010, 16'h0, 16'h12, 16'h22, 16'h0, 4'b0010, 16'h12, 4'b0100, 16'h24);
    step("wrap.c4", 4'hF, 4'b0000, 16'h0, 16'h12, 16'h22, 16'h0, 4'b0000, 16'h12, 4'b0010, 16'h14);

    // Fresh reset, then all four cores request continuously.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(4'hF, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      e_gnt  = 4'b0001 << (c % 4);
      e_addr = 16'(10 * ((c % 4) + 1));
      e_rv   = (c == 0) ? 4'b0000 : (4'b0001 << ((c + 3) % 4));
      e_rd   = 16'(10 * (((c + 3) % 4) + 1) + 2);
      step($sformatf("all.c%0d", c), 4'hF, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40,
           e_gnt, e_addr, e_rv, e_rd);
    end

    // Core 1 masked; its grant from the previous cycle still returns.
    step("mask.c0", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b0100, 16'd30, 4'b0010, 16'd22);
    step("mask.c1", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b1000, 16'd40, 4'b0100, 16'd32);
    step("mask.c2", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b0001, 16'd10, 4'b1000, 16'd42);
    step("mask.c3", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b0100, 16'd30, 4'b0001, 16'd12);
    step("mask.c4", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b1000, 16'd40, 4'b0100, 16'd32);
    step("mask.c5", 4'b1101, 4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 4'b0001, 16'd10, 4'b1000, 16'd42);

    // Idle hold after a grant to core 0 at 0x40.
    step("idle.c0", 4'hF, 4'b0001, 16'h40, 16'd20, 16'd30, 16'd40, 4'b0001, 16'h40, 4'b0001, 16'd12);
    step("idle.c1", 4'hF, 4'b0000, 16'h40, 16'd20, 16'd30, 16'd40, 4'b0000, 16'h40, 4'b0001, 16'h42);
    for (int c = 2; c < 6; c++) begin
      step($sformatf("idle.c%0d", c), 4'hF, 4'b0000, 16'h40, 16'd20, 16'd30, 16'd40,
           4'b0000, 16'h40, 4'b0000, 16'h0);
    end

    // Lone requester holding core_req is granted every cycle.
    step("solo.c0", 4'hF, 4'b0001, 16'h40, 16'h0, 16'h0, 16'h0, 4'b0001, 16'h40, 4'b0000, 16'h0);
    step("solo.c1", 4'hF, 4'b0001, 16'h40, 16'h0, 16'h0, 16'h0, 4'b0001, 16'h40, 4'b0001, 16'h42);
    step("solo.c2", 4'hF, 4'b0001, 16'h40, 16'h0, 16'h0, 16'h0, 4'b0001, 16'h40, 4'b0001, 16'h42);

    // Reset while a read to core 1 is in flight.
    step("rstmid.c0", 4'hF, 4'b0010, 16'h0, 16'h50, 16'h60, 16'h0, 4'b0010, 16'h50, 4'b0001, 16'h42);
    rst_n = 1'b0;
    drive(4'hF, 4'b0010, 16'h0, 16'h50, 16'h60, 16'h0);
    #4;
    chk("rstmid.gnt", 32'(bus.core_gnt), 32'h0);
    chk("rstmid.rvalid", 32'(bus.core_rvalid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rstmid.c1", 4'hF, 4'b0110, 16'h0, 16'h50, 16'h60, 16'h0, 4'b0010, 16'h50, 4'b0000, 16'h0);
    step("rstmid.c2", 4'hF, 4'b0100, 16'h0, 16'h50, 16'h60, 16'h0, 4'b0100, 16'h60, 4'b0010, 16'h52);
    step("rstmid.c3", 4'hF, 4'b0000, 16'h0, 16'h50, 16'h60, 16'h0, 4'b0000, 16'h60, 4'b0100, 16'h62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
